// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the 16-bit multicycle core front end:
// immediate selector encodings, instruction field positions, opcodes
// and the fetch state encoding.
package riscv16_pkg;

    // imm_src encodings driven by the controller
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // Instruction field LSB positions (all register/op fields are 3 bits)
    localparam int OP_LSB  = 0;
    localparam int RD_LSB  = 3;
    localparam int F3_LSB  = 6;
    localparam int RS1_LSB = 9;
    localparam int RS2_LSB = 12;

    // Opcodes, shared with the main controller
    localparam logic [2:0] OPC_RTYPE  = 3'd0;
    localparam logic [2:0] OPC_ITYPE  = 3'd1;
    localparam logic [2:0] OPC_LOAD   = 3'd2;
    localparam logic [2:0] OPC_STORE  = 3'd3;
    localparam logic [2:0] OPC_BRANCH = 3'd4;
    localparam logic [2:0] OPC_LUI    = 3'd5;
    localparam logic [2:0] OPC_JAL    = 3'd6;
    localparam logic [2:0] OPC_JALR   = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Bus between the controller/memory side and the fetch/decode unit.
// master = controller and memory read port, slave = fetch/decode unit.
interface instr_fetch_decode_if #(
    parameter int XLEN = 16,
    parameter int ILEN = 16
);
    logic            ir_write;
    logic [XLEN-1:0] pc_in;
    logic [2:0]      imm_src;
    logic [ILEN-1:0] mem_rdata;
    logic            mem_rvalid;
    logic            fetch_req;
    logic            fetch_busy;
    logic            instr_valid;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] old_pc;
    logic [2:0]      op;
    logic [2:0]      rd;
    logic [1:0]      branch_funct;
    logic [2:0]      func3;
    logic [2:0]      rs1;
    logic [2:0]      rs2;
    logic [XLEN-1:0] imm_ext;

    modport master (
        output ir_write, pc_in, imm_src, mem_rdata, mem_rvalid,
        input  fetch_req, fetch_busy, instr_valid, instr, old_pc,
               op, rd, branch_funct, func3, rs1, rs2, imm_ext
    );

    modport slave (
        input  ir_write, pc_in, imm_src, mem_rdata, mem_rvalid,
        output fetch_req, fetch_busy, instr_valid, instr, old_pc,
               op, rd, branch_funct, func3, rs1, rs2, imm_ext
    );
endinterface

// File: rtl/instr_fetch_decode_imm_extend.sv
// Immediate extraction and extension. Purely combinational so a later
// pipelined core can reuse it in its decode stage.
module imm_extend
    import riscv16_pkg::*;
#(
    parameter int XLEN = 16
) (
    input  logic [15:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm_ext
);

    // The opcode bits never contribute to an immediate.
    logic unused_op_bits;
    assign unused_op_bits = ^instr[2:0];

    // Select and extend the immediate format requested by the controller
    always_comb begin
        imm_ext = '0;
        case (imm_src)
            IMM_I:   imm_ext = {{(XLEN-4){instr[15]}}, instr[15:12]};
            IMM_S:   imm_ext = {{(XLEN-4){instr[15]}}, instr[15], instr[5:3]};
            IMM_B:   imm_ext = {{(XLEN-6){instr[15]}}, instr[15:12], instr[5], 1'b0};
            IMM_U:   imm_ext = {instr[15:9], {(XLEN-7){1'b0}}};
            IMM_J:   imm_ext = {{(XLEN-11){instr[15]}}, instr[15:6], 1'b0};
            default: imm_ext = '0;
        endcase
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode front end. Captures the instruction word on
// IRWrite, stalling the controller while memory is slow, and holds IR and
// OldPC until the next capture. Decode fields are slices of IR.
module instr_fetch_decode
    import riscv16_pkg::*;
#(
    parameter int              XLEN     = 16,
    parameter int              ILEN     = 16,
    parameter logic [XLEN-1:0] RESET_PC = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_decode_if.slave  bus
);

    fetch_state_e    state_q, state_d;
    logic [ILEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] old_pc_q, old_pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            valid_q, valid_d;

    // State and capture registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            old_pc_q  <= RESET_PC;
            pend_pc_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            old_pc_q  <= old_pc_d;
            pend_pc_q <= pend_pc_d;
            valid_q   <= valid_d;
        end
    end

    // Next state: zero-wait capture from IDLE, otherwise park the PC and wait.
    // ir_write in WAIT is ignored since the controller is frozen there.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        old_pc_d  = old_pc_q;
        pend_pc_d = pend_pc_q;
        valid_d   = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.ir_write) begin
                    if (bus.mem_rvalid) begin
                        instr_d  = bus.mem_rdata;
                        old_pc_d = bus.pc_in;
                        valid_d  = 1'b1;
                    end else begin
                        pend_pc_d = bus.pc_in;
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    instr_d  = bus.mem_rdata;
                    old_pc_d = pend_pc_q;
                    valid_d  = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs; busy drops in the data-valid cycle so the controller
    // advances on the same edge that captures IR. Both are held low in reset.
    always_comb begin
        bus.fetch_req  = 1'b0;
        bus.fetch_busy = 1'b0;
        if (rst) begin
            case (state_q)
                ST_IDLE: begin
                    bus.fetch_req  = bus.ir_write;
                    bus.fetch_busy = bus.ir_write & ~bus.mem_rvalid;
                end
                ST_WAIT: begin
                    bus.fetch_req  = 1'b1;
                    bus.fetch_busy = ~bus.mem_rvalid;
                end
                default: begin
                    bus.fetch_req  = 1'b0;
                    bus.fetch_busy = 1'b0;
                end
            endcase
        end
    end

    assign bus.instr_valid  = valid_q;
    assign bus.instr        = instr_q;
    assign bus.old_pc       = old_pc_q;
    assign bus.op           = instr_q[OP_LSB  +: 3];
    assign bus.rd           = instr_q[RD_LSB  +: 3];
    // Branch format has no rd, so its funct shares those bits.
    assign bus.branch_funct = instr_q[RD_LSB  +: 2];
    assign bus.func3        = instr_q[F3_LSB  +: 3];
    assign bus.rs1          = instr_q[RS1_LSB +: 3];
    assign bus.rs2          = instr_q[RS2_LSB +: 3];

    imm_extend #(.XLEN(XLEN)) u_imm_extend (
        .instr   (instr_q),
        .imm_src (bus.imm_src),
        .imm_ext (bus.imm_ext)
    );

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    instr_fetch_decode_if #(.XLEN(16), .ILEN(16)) bus ();

    instr_fetch_decode #(.XLEN(16), .ILEN(16), .RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        bus.ir_write   = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 16'h0000;
    endtask

    // Zero-wait fetch used to load IR for later scenarios
    task automatic fetch_word(input logic [15:0] pc, input logic [15:0] data);
        @(posedge clk); #1;
        bus.pc_in      = pc;
        bus.ir_write   = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = data;
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.pc_in      = 16'h1234;
        bus.imm_src    = 3'd0;
        bus.ir_write   = 1'b1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (bus.instr !== 16'h0000) $display("FAIL reset_instr got=%h exp=0000", bus.instr);
        else n_pass++;
        n_total++;
        if (bus.old_pc !== 16'h0000) $display("FAIL reset_old_pc got=%h exp=0000", bus.old_pc);
        else n_pass++;
        n_total++;
        if (bus.instr_valid !== 1'b0) $display("FAIL reset_instr_valid got=%b exp=0", bus.instr_valid);
        else n_pass++;
        n_total++;
        if (bus.fetch_req !== 1'b0 || bus.fetch_busy !== 1'b0)
            $display("FAIL reset_handshake got req=%b busy=%b exp req=0 busy=0", bus.fetch_req, bus.fetch_busy);
        else n_pass++;
        drive_idle();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        int busy_seen;
        @(posedge clk); #1;
        bus.pc_in      = 16'h0040;
        bus.ir_write   = 1'b1;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.fetch_busy !== 1'b1) $display("FAIL midwait_busy_before got=%b exp=1", bus.fetch_busy);
        else n_pass++;
        @(posedge clk); #1;
        bus.ir_write = 1'b0;
        rst = 1'b0;
        #1;
        n_total++;
        if (bus.fetch_busy !== 1'b0 || bus.fetch_req !== 1'b0)
            $display("FAIL midwait_rst_handshake got req=%b busy=%b exp req=0 busy=0", bus.fetch_req, bus.fetch_busy);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        busy_seen = 0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'hABCD;
        @(negedge clk);
        if (bus.fetch_busy !== 1'b0 || bus.fetch_req !== 1'b0) busy_seen++;
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        if (bus.fetch_busy !== 1'b0 || bus.fetch_req !== 1'b0) busy_seen++;
        n_total++;
        if (busy_seen != 0) $display("FAIL midwait_late_rvalid_handshake got=%0d bad cycles exp=0", busy_seen);
        else n_pass++;
        n_total++;
        if (bus.instr !== 16'h0000 || bus.instr_valid !== 1'b0)
            $display("FAIL midwait_late_rvalid_ignored got instr=%h valid=%b exp instr=0000 valid=0", bus.instr, bus.instr_valid);
        else n_pass++;
    endtask

    task automatic test_zero_wait();
        @(posedge clk); #1;
        bus.pc_in      = 16'h0010;
        bus.ir_write   = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'h1A53;
        @(negedge clk);
        n_total++;
        if (bus.fetch_req !== 1'b1 || bus.fetch_busy !== 1'b0)
            $display("FAIL zw_handshake got req=%b busy=%b exp req=1 busy=0", bus.fetch_req, bus.fetch_busy);
        else n_pass++;
        @(posedge clk); #1;
        drive_idle();
        n_total++;
        if (bus.instr !== 16'h1A53 || bus.old_pc !== 16'h0010 || bus.instr_valid !== 1'b1)
            $display("FAIL zw_capture got instr=%h old_pc=%h valid=%b exp 1a53 0010 1",
                     bus.instr, bus.old_pc, bus.instr_valid);
        else n_pass++;
        n_total++;
        if (bus.op !== 3'd3 || bus.rd !== 3'd2 || bus.func3 !== 3'd1 ||
            bus.rs1 !== 3'd5 || bus.rs2 !== 3'd1 || bus.branch_funct !== 2'd2)
            $display("FAIL zw_decode got op=%0d rd=%0d f3=%0d rs1=%0d rs2=%0d bf=%0d exp 3 2 1 5 1 2",
                     bus.op, bus.rd, bus.func3, bus.rs1, bus.rs2, bus.branch_funct);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.fetch_busy !== 1'b0 || bus.fetch_req !== 1'b0)
            $display("FAIL zw_after got req=%b busy=%b exp req=0 busy=0", bus.fetch_req, bus.fetch_busy);
        else n_pass++;
    endtask

    task automatic test_latency();
        int busy_cnt;
        int hold_bad;
        busy_cnt = 0;
        hold_bad = 0;
        @(posedge clk); #1;
        bus.pc_in      = 16'h0020;
        bus.ir_write   = 1'b1;
        bus.mem_rvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.fetch_busy === 1'b1 && bus.fetch_req === 1'b1) busy_cnt++;
            if (bus.instr !== 16'h1A53 || bus.old_pc !== 16'h0010) hold_bad++;
            @(posedge clk); #1;
            bus.pc_in    = 16'h0022;
            bus.ir_write = (c == 0);
        end
        n_total++;
        if (busy_cnt != 3) $display("FAIL lat_busy_cycles got=%0d exp=3", busy_cnt);
        else n_pass++;
        n_total++;
        if (hold_bad != 0) $display("FAIL lat_ir_hold got=%0d changed cycles exp=0", hold_bad);
        else n_pass++;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'h0020;
        @(negedge clk);
        n_total++;
        if (bus.fetch_busy !== 1'b0 || bus.fetch_req !== 1'b1)
            $display("FAIL lat_valid_cycle got req=%b busy=%b exp req=1 busy=0", bus.fetch_req, bus.fetch_busy);
        else n_pass++;
        @(posedge clk); #1;
        drive_idle();
        n_total++;
        if (bus.instr !== 16'h0020 || bus.old_pc !== 16'h0020)
            $display("FAIL lat_capture got instr=%h old_pc=%h exp instr=0020 old_pc=0020", bus.instr, bus.old_pc);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.fetch_busy !== 1'b0 || bus.fetch_req !== 1'b0)
            $display("FAIL lat_back_idle got req=%b busy=%b exp req=0 busy=0", bus.fetch_req, bus.fetch_busy);
        else n_pass++;
    endtask

    task automatic test_data_access();
        fetch_word(16'h0010, 16'h1A53);
        bus.ir_write   = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 16'hBEEF;
        bus.pc_in      = 16'h0030;
        @(negedge clk);
        n_total++;
        if (bus.fetch_req !== 1'b0 || bus.fetch_busy !== 1'b0)
            $display("FAIL data_handshake got req=%b busy=%b exp req=0 busy=0", bus.fetch_req, bus.fetch_busy);
        else n_pass++;
        @(posedge clk); #1;
        drive_idle();
        n_total++;
        if (bus.instr !== 16'h1A53 || bus.old_pc !== 16'h0010)
            $display("FAIL data_ir_hold got instr=%h old_pc=%h exp instr=1a53 old_pc=0010", bus.instr, bus.old_pc);
        else n_pass++;
    endtask

    task automatic test_immediates();
        logic [15:0] t_instr [0:7];
        logic [2:0]  t_src   [0:7];
        logic [15:0] t_exp   [0:7];
        t_instr[0] = 16'hE000; t_src[0] = 3'd0; t_exp[0] = 16'hFFFE;
        t_instr[1] = 16'h0020; t_src[1] = 3'd2; t_exp[1] = 16'h0002;
        t_instr[2] = 16'hFE00; t_src[2] = 3'd3; t_exp[2] = 16'hFE00;
        t_instr[3] = 16'h8000; t_src[3] = 3'd4; t_exp[3] = 16'hFC00;
        t_instr[4] = 16'h8028; t_src[4] = 3'd1; t_exp[4] = 16'hFFFD;
        t_instr[5] = 16'hFFFF; t_src[5] = 3'd6; t_exp[5] = 16'h0000;
        t_instr[6] = 16'hFFFF; t_src[6] = 3'd5; t_exp[6] = 16'h0000;
        t_instr[7] = 16'h7FC0; t_src[7] = 3'd4; t_exp[7] = 16'h03FE;
        for (int i = 0; i < 8; i++) begin
            fetch_word(16'h0100 + 16'(i * 2), t_instr[i]);
            bus.imm_src = t_src[i];
            @(negedge clk);
            n_total++;
            if (bus.imm_ext !== t_exp[i])
                $display("FAIL imm_%0d instr=%h src=%0d got=%h exp=%h",
                         i, t_instr[i], t_src[i], bus.imm_ext, t_exp[i]);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_reset_mid_wait();
        test_zero_wait();
        test_latency();
        test_data_access();
        test_immediates();
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Instruction-side front end of the 16-bit multicycle core. Sits between the unified memory read port and the controller.
- On the controller's IRWrite it fetches the instruction word, absorbing variable memory latency with a stall handshake. It latches IR and OldPC.
- It drives the decoded op/func3/Branch_funct/register fields to the controller and datapath, plus the extended immediate selected by immSrc.

Parameters:
- XLEN, 16, datapath and PC width
- ILEN, 16, instruction width
- RESET_PC, 16'h0000, reset value of old_pc

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low (asserted when 0)
- ir_write  input  1  IRWrite from controller, request instruction capture
- pc_in  input  XLEN  current PC register value
- imm_src  input  3  immSrc from controller
- mem_rdata  input  ILEN  memory read data
- mem_rvalid  input  1  mem_rdata valid this cycle
- fetch_req  output  1  instruction fetch outstanding (memory qualifier)
- fetch_busy  output  1  stall, freezes controller FSM and PC while 1
- instr_valid  output  1  IR holds a fetched instruction
- instr  output  ILEN  IR contents
- old_pc  output  XLEN  PC of the instruction in IR
- op  output  3  instr[2:0]
- rd  output  3  instr[5:3]
- branch_funct  output  2  instr[4:3]
- func3  output  3  instr[8:6]
- rs1  output  3  instr[11:9]
- rs2  output  3  instr[14:12]
- imm_ext  output  XLEN  extended immediate

Behaviour:
- Reset (rst=0, async): state=IDLE, instr=0, old_pc=RESET_PC, pend_pc=0, instr_valid=0. fetch_req and fetch_busy are forced 0 while in reset.
- FSM states: IDLE, WAIT.
- IDLE with ir_write=1 and mem_rvalid=1 (zero-wait): at the clock edge instr<=mem_rdata, old_pc<=pc_in, instr_valid<=1. Stay IDLE. fetch_req=1 and fetch_busy=0 that cycle.
- IDLE with ir_write=1 and mem_rvalid=0: pend_pc<=pc_in, go to WAIT. fetch_req=1 and fetch_busy=1 that cycle (combinational, same cycle).
- WAIT: fetch_req=1, fetch_busy=1.
  - On mem_rvalid=1: instr<=mem_rdata, old_pc<=pend_pc, instr_valid<=1, go to IDLE. fetch_busy=0 in that cycle, so the controller advances on the same edge as the capture.
- ir_write while in WAIT is ignored (the controller is frozen). pend_pc is never overwritten in WAIT.
- mem_rvalid in IDLE without ir_write is a data access. It is ignored, and IR/old_pc hold.
- IR and old_pc change only on a capture edge. They hold across data-memory states and register writeback.
- instr_valid stays 1 after the first capture until reset.
- Reset in WAIT: the fetch is abandoned, and a late mem_rvalid after reset release with no ir_write is ignored.
- Decode fields are combinational slices of instr. branch_funct aliases rd[1:0] by design (branch format has no rd).
- imm_ext is combinational from instr and imm_src. sext = sign-extend to XLEN from the MSB of the listed field.
  - 0 I: sext(instr[15:12])
  - 1 S: sext({instr[15],instr[5:3]})
  - 2 B: sext({instr[15:12],instr[5],1'b0})
  - 3 U: {instr[15:9],9'b0}
  - 4 J: sext({instr[15:6],1'b0})
  - 5-7: 16'h0000
- No X propagation: all outputs are defined at all times after reset.

Decomposition:
- Package riscv16_pkg: IMM_I/S/B/U/J encodings of imm_src, field bit-position constants (OP_LSB, RD_LSB, F3_LSB, RS1_LSB, RS2_LSB), opcode constants shared with the main controller, and the fetch state enum.
- One combinational sub-module, imm_extend (instr, imm_src -> imm_ext), reusable by a future pipelined core.
- FSM, IR and PC latches stay in the top.

Test Plan:
- Reset mid-WAIT: issue ir_write with mem_rvalid=0, assert rst=0, release, then pulse mem_rvalid with no ir_write -> state IDLE, instr=0, instr_valid=0, fetch_busy=0 throughout.
- Zero-wait fetch: pc_in=16'h0010, ir_write=1, mem_rvalid=1, mem_rdata=16'h1A53 -> next edge instr=16'h1A53, old_pc=16'h0010, op=3, rd=2, func3=1, rs1=5, rs2=1. fetch_busy stays 0.
- 3-cycle latency: pc_in=16'h0020, ir_write=1, mem_rvalid after 3 cycles with 16'h0020 -> fetch_busy=1 for 3 cycles, 0 in the valid cycle. old_pc=16'h0020 even though pc_in changes to 16'h0022 during WAIT. A second ir_write during WAIT is ignored.
- Data access isolation: IR=16'h1A53, IDLE, mem_rvalid=1 with mem_rdata=16'hBEEF and ir_write=0 -> instr and old_pc unchanged, fetch_req=0.
- Immediates:
  - instr=16'hE000, imm_src=0 -> 16'hFFFE
  - instr=16'h0020, imm_src=2 -> 16'h0002
  - instr=16'hFE00, imm_src=3 -> 16'hFE00
  - instr=16'h8000, imm_src=4 -> 16'hFC00
  - instr=16'h8028, imm_src=1 -> 16'hFFFD
  - imm_src=6 -> 16'h0000
